// File: rtl/fp_add_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_add_pipe                                                     |
// | Brief    : Pipelined parametrised FP adder (bf16 default) with valid/ready |
// |            flow control. Define FP_ADD_RNE_EN for round-to-nearest-even,   |
// |            otherwise truncation with saturating overflow.                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fp_add_pipe #(
    parameter int E_W = 8,
    parameter int M_W = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic           sa_i,
    input  logic [E_W-1:0] ea_i,
    input  logic [M_W-1:0] ma_i,
    input  logic           sb_i,
    input  logic [E_W-1:0] eb_i,
    input  logic [M_W-1:0] mb_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic           s_o,
    output logic [E_W-1:0] e_o,
    output logic [M_W-1:0] m_o,
    output logic [2:0]     flags_o
);
    localparam int c_SW  = M_W + 4;
    localparam int c_XW  = E_W + 2;
    localparam int c_LZW = $clog2(c_SW + 1);
    localparam logic [E_W-1:0] c_EMAX   = {E_W{1'b1}};
    localparam logic [M_W-1:0] c_QNAN_M = {1'b1, {(M_W-1){1'b0}}};

    logic w_adv;
    assign w_adv   = !valid_o || ready_i;
    assign ready_o = w_adv;

    // Operands are registered on accept; align, add and normalise follow.
    logic           r_in_valid, r_in_sa, r_in_sb;
    logic [E_W-1:0] r_in_ea, r_in_eb;
    logic [M_W-1:0] r_in_ma, r_in_mb;

    logic           w_az, w_bz, w_ainf, w_binf, w_anan, w_bnan, w_a_ge_b, w_inf_inf, w_snan;
    logic [M_W-1:0] w_maf, w_mbf;
    logic           w_big_s;
    logic [E_W-1:0] w_big_e, w_sml_e, w_diff;
    logic [M_W:0]   w_big_sig, w_sml_sig;
    logic [M_W+2:0] w_sml_pre, w_sml_shf;
    logic           w_sml_stk;
    logic           w_spec;
    logic [E_W+M_W:0] w_spec_res;
    logic [2:0]     w_spec_flg;

    always_comb begin
        w_az      = (r_in_ea == '0);
        w_bz      = (r_in_eb == '0);
        w_ainf    = (r_in_ea == c_EMAX) && (r_in_ma == '0);
        w_binf    = (r_in_eb == c_EMAX) && (r_in_mb == '0);
        w_anan    = (r_in_ea == c_EMAX) && (r_in_ma != '0);
        w_bnan    = (r_in_eb == c_EMAX) && (r_in_mb != '0);
        w_inf_inf = w_ainf && w_binf && (r_in_sa != r_in_sb);
        w_snan    = (w_anan && !r_in_ma[M_W-1]) || (w_bnan && !r_in_mb[M_W-1]);
        w_maf     = w_az ? '0 : r_in_ma;
        w_mbf     = w_bz ? '0 : r_in_mb;
        w_a_ge_b  = {r_in_ea, w_maf} >= {r_in_eb, w_mbf};
        if (w_a_ge_b) begin
            w_big_s   = r_in_sa;
            w_big_e   = r_in_ea;
            w_sml_e   = r_in_eb;
            w_big_sig = {~w_az, w_maf};
            w_sml_sig = {~w_bz, w_mbf};
        end else begin
            w_big_s   = r_in_sb;
            w_big_e   = r_in_eb;
            w_sml_e   = r_in_ea;
            w_big_sig = {~w_bz, w_mbf};
            w_sml_sig = {~w_az, w_maf};
        end
        w_diff    = w_big_e - w_sml_e;
        w_sml_pre = {w_sml_sig, 2'b00};
        if (32'(w_diff) >= 32'(M_W + 3)) begin
            w_sml_shf = '0;
            w_sml_stk = |w_sml_sig;
        end else begin
            w_sml_shf = w_sml_pre >> w_diff;
            w_sml_stk = |(w_sml_pre & ~({(M_W+3){1'b1}} << w_diff));
        end
        w_spec     = 1'b1;
        w_spec_flg = '0;
        if (w_anan || w_bnan || w_inf_inf) begin
            w_spec_res = {1'b0, c_EMAX, c_QNAN_M};
            w_spec_flg = {w_snan || w_inf_inf, 2'b00};
        end else if (w_ainf) begin
            w_spec_res = {r_in_sa, c_EMAX, {M_W{1'b0}}};
        end else if (w_binf) begin
            w_spec_res = {r_in_sb, c_EMAX, {M_W{1'b0}}};
        end else if (w_az && w_bz) begin
            w_spec_res = {r_in_sa & r_in_sb, {(E_W+M_W){1'b0}}};
        end else begin
            w_spec     = 1'b0;
            w_spec_res = '0;
        end
    end

    logic              r_al_valid, r_al_s, r_al_sub, r_al_spec;
    logic [E_W-1:0]    r_al_e;
    logic [c_SW-1:0]   r_al_big, r_al_sml;
    logic [E_W+M_W:0]  r_al_spec_res;
    logic [2:0]        r_al_spec_flg;

    // Swap guarantees big >= small, so the subtraction never borrows out.
    logic [c_SW:0] w_sum;
    assign w_sum = r_al_sub ? ({1'b0, r_al_big} - {1'b0, r_al_sml})
                            : ({1'b0, r_al_big} + {1'b0, r_al_sml});

    logic              r_sm_valid, r_sm_s, r_sm_spec;
    logic [E_W-1:0]    r_sm_e;
    logic [c_SW:0]     r_sm_sum;
    logic [E_W+M_W:0]  r_sm_spec_res;
    logic [2:0]        r_sm_spec_flg;

    logic [c_LZW-1:0] w_lzc;
    logic [c_SW-1:0]  w_norm;
    logic [c_XW-1:0]  w_exp_n, w_exp_r;
    logic [M_W+1:0]   w_mant_r;
    logic [M_W-1:0]   w_mant_f;
    logic             w_inexact, w_rup;
    logic             w_res_s;
    logic [E_W-1:0]   w_res_e;
    logic [M_W-1:0]   w_res_m;
    logic [2:0]       w_res_flg;

    always_comb begin
        w_lzc = c_LZW'(c_SW);
        for (int i = 0; i < c_SW; i++) begin
            if (r_sm_sum[i]) w_lzc = c_LZW'(c_SW - 1 - i);
        end
        if (r_sm_sum[c_SW]) begin
            w_norm  = {r_sm_sum[c_SW:2], r_sm_sum[1] | r_sm_sum[0]};
            w_exp_n = c_XW'(r_sm_e) + c_XW'(1);
        end else begin
            w_norm  = r_sm_sum[c_SW-1:0] << w_lzc;
            w_exp_n = c_XW'(r_sm_e) - c_XW'(w_lzc);
        end
        w_inexact = |w_norm[2:0];
`ifdef FP_ADD_RNE_EN
        w_rup = w_norm[2] && (w_norm[1] || w_norm[0] || w_norm[3]);
`else
        w_rup = 1'b0;
`endif
        w_mant_r = {1'b0, 1'b1, w_norm[c_SW-2:3]} + (M_W+2)'(w_rup);
        w_exp_r  = w_exp_n + c_XW'(w_mant_r[M_W+1]);
        w_mant_f = w_mant_r[M_W+1] ? w_mant_r[M_W:1] : w_mant_r[M_W-1:0];

        w_res_s   = r_sm_s;
        w_res_e   = w_exp_r[E_W-1:0];
        w_res_m   = w_mant_f;
        w_res_flg = {2'b00, w_inexact};
        if (r_sm_spec) begin
            {w_res_s, w_res_e, w_res_m} = r_sm_spec_res;
            w_res_flg = r_sm_spec_flg;
        end else if (r_sm_sum == '0) begin
            w_res_s   = 1'b0;
            w_res_e   = '0;
            w_res_m   = '0;
            w_res_flg = '0;
        end else if (w_exp_n[c_XW-1] || (w_exp_n == '0)) begin
            w_res_e   = '0;
            w_res_m   = '0;
            w_res_flg = 3'b001;
        end else if (w_exp_r >= {2'b00, c_EMAX}) begin
`ifdef FP_ADD_RNE_EN
            w_res_e   = c_EMAX;
            w_res_m   = '0;
`else
            w_res_e   = c_EMAX - E_W'(1);
            w_res_m   = {M_W{1'b1}};
`endif
            w_res_flg = 3'b011;
        end
    end

    // Control and output state: cleared on reset, frozen as a whole when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid <= 1'b0;
            r_al_valid <= 1'b0;
            r_sm_valid <= 1'b0;
            valid_o    <= 1'b0;
            s_o        <= 1'b0;
            e_o        <= '0;
            m_o        <= '0;
            flags_o    <= '0;
        end else if (w_adv) begin
            r_in_valid <= valid_i;
            r_al_valid <= r_in_valid;
            r_sm_valid <= r_al_valid;
            valid_o    <= r_sm_valid;
            s_o        <= w_res_s;
            e_o        <= w_res_e;
            m_o        <= w_res_m;
            flags_o    <= w_res_flg;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_in_sa       <= sa_i;
            r_in_ea       <= ea_i;
            r_in_ma       <= ma_i;
            r_in_sb       <= sb_i;
            r_in_eb       <= eb_i;
            r_in_mb       <= mb_i;
            r_al_s        <= w_big_s;
            r_al_e        <= w_big_e;
            r_al_sub      <= r_in_sa ^ r_in_sb;
            r_al_big      <= {w_big_sig, 3'b000};
            r_al_sml      <= {w_sml_shf, w_sml_stk};
            r_al_spec     <= w_spec;
            r_al_spec_res <= w_spec_res;
            r_al_spec_flg <= w_spec_flg;
            r_sm_s        <= r_al_s;
            r_sm_e        <= r_al_e;
            r_sm_sum      <= w_sum;
            r_sm_spec     <= r_al_spec;
            r_sm_spec_res <= r_al_spec_res;
            r_sm_spec_flg <= r_al_spec_flg;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_add_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fp_add_pipe                                                  |
// | Brief    : Directed-vector bench for fp_add_pipe (bf16 default build).     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fp_add_pipe;
    logic       clk = 1'b0;
    logic       rst, valid_i, ready_o, ready_i, valid_o;
    logic       sa_i, sb_i, s_o;
    logic [7:0] ea_i, eb_i, e_o;
    logic [6:0] ma_i, mb_i, m_o;
    logic [2:0] flags_o;

    always #5 clk = ~clk;

    fp_add_pipe dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .sa_i(sa_i), .ea_i(ea_i), .ma_i(ma_i),
        .sb_i(sb_i), .eb_i(eb_i), .mb_i(mb_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .s_o(s_o), .e_o(e_o), .m_o(m_o), .flags_o(flags_o)
    );

    localparam int c_NV = 18;
    logic [15:0] va [c_NV];
    logic [15:0] vb [c_NV];
    logic [18:0] ve [c_NV];   // {result, invalid, overflow, inexact}
    logic [18:0] q [$];
    logic [18:0] held;
    logic        held_v;
    int n_chk = 0, n_pass = 0, cyc = 0, first_acc = -1, first_vld = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One cycle: drive, observe away from the rising edge, then wait for the next falling edge.
    task automatic step(input logic vin, input logic [15:0] a, input logic [15:0] b,
                        input logic [18:0] e, input logic rdy, output logic took);
        logic [18:0] got, want;
        valid_i = vin;
        {sa_i, ea_i, ma_i} = a;
        {sb_i, eb_i, mb_i} = b;
        ready_i = rdy;
        #1;
        got = {s_o, e_o, m_o, flags_o};
        if (valid_o && first_vld < 0) first_vld = cyc;
        if (valid_o && !ready_i) begin
            if (held_v) chk("stall_hold", 32'(got), 32'(held));
            held   = got;
            held_v = 1'b1;
        end else begin
            held_v = 1'b0;
        end
        if (valid_o && ready_i) begin
            if (q.size() == 0) chk("spurious_valid", 32'(valid_o), 32'(0));
            else begin
                want = q.pop_front();
                chk("result", 32'(got), 32'(want));
            end
        end
        took = valid_i && ready_o;
        if (took) begin
            q.push_back(e);
            if (first_acc < 0) first_acc = cyc;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_stream(input int start, input int count, input logic stall);
        int   idx = start;
        int   c = 0;
        logic took, rdy;
        while ((idx < start + count || q.size() > 0) && c < 60) begin
            rdy = !(stall && c >= 6 && c < 10);
            if (idx < start + count) step(1'b1, va[idx], vb[idx], ve[idx], rdy, took);
            else step(1'b0, 16'h0, 16'h0, 19'h0, rdy, took);
            if (took) idx++;
            c++;
        end
        chk("drain", 32'(start + count - idx) + 32'(q.size()), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic took;
        va = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h3F80, 16'h3F80, 16'h4040, 16'h3F80, 16'h3F81,
               16'h7F80, 16'h7F80, 16'h7F7F, 16'h0081, 16'h7FC1, 16'h7F81, 16'h4000, 16'h3F80, 16'hBF80};
        vb = '{16'h0000, 16'h8000, 16'h8000, 16'hBF80, 16'h3F80, 16'hBF80, 16'hBF80, 16'h3B80, 16'h3B80,
               16'hFF80, 16'h3F80, 16'h7F7F, 16'h8080, 16'h3F80, 16'h0000, 16'h3F80, 16'h3580, 16'hBF80};
        ve = '{{16'h0000, 3'b000}, {16'h0000, 3'b000}, {16'h8000, 3'b000}, {16'hBF80, 3'b000},
               {16'h4000, 3'b000}, {16'h0000, 3'b000}, {16'h4000, 3'b000}, {16'h3F80, 3'b001},
               {16'h3F81, 3'b001}, {16'h7FC0, 3'b100}, {16'h7F80, 3'b000}, {16'h7F7F, 3'b011},
               {16'h0000, 3'b001}, {16'h7FC0, 3'b000}, {16'h7FC0, 3'b100}, {16'h4040, 3'b000},
               {16'h3F80, 3'b001}, {16'hC000, 3'b000}};
`ifdef FP_ADD_RNE_EN
        ve[8]  = {16'h3F82, 3'b001};
        ve[11] = {16'h7F80, 3'b011};
`endif
        held   = '0;
        held_v = 1'b0;
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        {sa_i, ea_i, ma_i} = 16'h0;
        {sb_i, eb_i, mb_i} = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'(0));
        chk("rst_outputs", 32'({s_o, e_o, m_o, flags_o}), 32'(0));
        chk("rst_ready_o", 32'(ready_o), 32'(1));
        @(negedge clk);

        run_stream(0, c_NV, 1'b1);
        // Accepting step k: result visible in step k+4, i.e. after the third edge past acceptance.
        chk("latency", 32'(first_vld - first_acc), 32'(4));

        step(1'b1, va[4], vb[4], ve[4], 1'b1, took);
        step(1'b1, va[15], vb[15], ve[15], 1'b1, took);
        rst = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_valid_o", 32'(valid_o), 32'(0));
        chk("midrst_outputs", 32'({s_o, e_o, m_o, flags_o}), 32'(0));
        rst = 1'b0;
        q.delete();
        held_v = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_valid", 32'(valid_o), 32'(0));
            step(1'b0, 16'h0, 16'h0, 19'h0, 1'b1, took);
        end

        run_stream(4, 6, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, pipelined IEEE-style floating-point adder. It generalises the combinational bf16 adder to any exponent/mantissa width and defaults to bf16. It adds a 3-stage pipeline with valid/ready flow control, round-to-nearest-even and exception flags. It sits between operand-issue logic and result writeback in the FP datapath and sustains one addition per cycle.

## Interface
- `E_W`, 8, exponent width in bits (bias = 2^(E_W-1)-1).
- `M_W`, 7, stored mantissa width in bits (hidden bit not stored).
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  operand pair valid.
- `ready_o`  out  1  block can accept operands this cycle.
- `sa_i`, `ea_i`, `ma_i`  in  1 / E_W / M_W  operand A sign, exponent, mantissa.
- `sb_i`, `eb_i`, `mb_i`  in  1 / E_W / M_W  operand B sign, exponent, mantissa.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  downstream accepts result.
- `s_o`, `e_o`, `m_o`  out  1 / E_W / M_W  result sign, exponent, mantissa.
- `flags_o`  out  3  {invalid, overflow, inexact}, aligned with result.

## Operation
- Stage 1 (classify/align): detect zero (e=0; subnormal inputs flushed to signed zero), inf (e all ones, m=0) and NaN (e all ones, m≠0). Swap so the larger magnitude is first. Right-shift the smaller significand (hidden bit prepended) by the exponent difference into M_W+1 bits plus guard, round and sticky. Shifts ≥ M_W+3 collapse to sticky only.
- Stage 2 (add): effective subtract when signs differ. The M_W+4-bit magnitude add/sub never goes negative because of the swap. The result sign is the sign of the larger operand.
- Stage 3 (normalise/round): handle carry-out (shift right 1, exp+1) or leading-zero count (shift left, exp−lzc). Round per Configuration. A rounding carry renormalises.
- Exact zero from cancellation gives +0. (−0)+(−0) gives −0. (+0)+(−0) gives +0.
- Exponent ≥ all-ones after rounding gives signed inf, overflow=1, inexact=1.
- Exponent ≤ 0 after normalise gives signed zero, inexact=1. Subnormals are not produced.
- Any NaN input, or inf + (−inf), gives canonical qNaN: s=0, e all ones, m=1<<(M_W-1). invalid=1 only for inf−inf or a signalling NaN (m MSB=0).
- inf + finite gives that inf with flags 0.
- inexact=1 whenever any discarded bit (guard/round/sticky) is non-zero.

## Timing
- Latency is 3 cycles: operands accepted at edge N appear with `valid_o`=1 after edge N+3 when there is no stall.
- Throughput is 1 op/cycle.
- Global advance enable `adv = !valid_o || ready_i`, and `ready_o = adv`. Every stage register loads only when `adv`=1, so the pipeline freezes as a whole.
- Bubbles (valid_i=0) propagate as valid=0 stage entries. They are not compressed.
- While `valid_o`=1 and `ready_i`=0, the outputs and `flags_o` hold stable.
- Transfer in occurs when valid_i && ready_o. Transfer out occurs when valid_o && ready_i. Both may happen in the same cycle.
- Reset: all stage valid bits go to 0. `valid_o`=0, `s_o`=0, `e_o`=0, `m_o`=0, `flags_o`=0. `ready_o`=1 the cycle after reset deasserts.
- Reset mid-operation discards all in-flight results. No partial output appears.

## Configuration
- `FP_ADD_RNE_EN` defined: round-to-nearest, ties-to-even using guard/round/sticky.
- `FP_ADD_RNE_EN` undefined: truncation (round toward zero). Overflow saturates to max finite (e=all-ones−1, m=all ones) instead of inf; the overflow and inexact flags are still set.
- Latency and the interface are identical in both builds.

## Test plan
- Zeros, bf16 default: 0x0000+0x0000 → 0x0000. 0x0000+0x8000 → 0x0000. 0x8000+0x8000 → 0x8000. 0x0000+0xBF80 → 0xBF80. Flags 0 in all cases.
- Basic: 0x3F80+0x3F80 → 0x4000. 0x3F80+0xBF80 → 0x0000. 0x4040+0xBF80 (3−1) → 0x4000. Flags 0.
- Rounding (RNE): 0x3F80+0x3B80 → 0x3F80, inexact. 0x3F81+0x3B80 → 0x3F82, inexact. Without the macro, the second case → 0x3F81.
- Specials: 0x7F80+0xFF80 → 0x7FC0, invalid. 0x7F80+0x3F80 → 0x7F80, flags 0. 0x7F7F+0x7F7F → 0x7F80 with overflow and inexact (without the macro: 0x7F7F).
- Flow control: stream 8 back-to-back ops and hold `ready_i`=0 for 4 cycles mid-stream → no loss or duplication, outputs stable while stalled, results in order, first result exactly 3 cycles after first accept.
- Reset: assert `rst` with 2 ops in flight → `valid_o`=0 and all outputs 0 next cycle. No stale result appears after release.
